// File: rtl/adc_par_sampler.sv
// adc_par_sampler: self-timed controller for the parallel 1.8 V ADC.
// Power-up sequencing, rate timer, EOC timeout and 2^N averaging.
module adc_par_sampler #(
  parameter int DATA_W       = 8,
  parameter int PWRUP_CYC    = 16,
  parameter int CONV_LOW_CYC = 4,
  parameter int EOC_TIMEOUT  = 200,
  parameter int RD_LOW_CYC   = 6,
  parameter int RD_SETUP_CYC = 2,
  parameter int AVG_LOG2     = 0
) (
  input  logic              clk_100M,
  input  logic              Reset,
  input  logic              enable,
  input  logic [15:0]       period_cyc,
  input  logic              clear_err,
  input  logic              EOC_18,
  input  logic [DATA_W-1:0] DB_in,
  output logic              CONVST_18,
  output logic              RD_18,
  output logic              PD_18,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WAIT_EOC,
    READ
  } state_t;

  localparam int M1 = (CONV_LOW_CYC > RD_LOW_CYC) ?
                      CONV_LOW_CYC : RD_LOW_CYC;
  localparam int CNT_MAX = (M1 > EOC_TIMEOUT) ? M1 : EOC_TIMEOUT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int PW_W  = $clog2(PWRUP_CYC + 1) + 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int AC_W  = AVG_LOG2 + 1;
  localparam int NAVG  = 1 << AVG_LOG2;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [15:0]        timer;
  logic [15:0]        timer_n;
  logic               convst_n;
  logic               rd_n;
  logic               to_set;
  logic               cap_en;
  logic               to_idle;
  logic               start_ok;
  logic               eoc_m;
  logic               eoc_s;
  logic [PW_W-1:0]    pwr_cnt;
  logic [DATA_W-1:0]  cap_data;
  logic               cap_vld;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   avg_shift;
  logic [DATA_W-1:0]  avg_out;
  logic [AC_W-1:0]    avg_cnt;
  logic               avg_last;

  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      pwr_cnt <= '0;
      PD_18   <= 1'b0;
    end else if (!PD_18) begin
      if (pwr_cnt == PW_W'(PWRUP_CYC - 1))
        PD_18 <= 1'b1;
      else
        pwr_cnt <= pwr_cnt + PW_W'(1);
    end
  end

  // Synchroniser idles high so reset never looks like an EOC.
  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      eoc_m <= 1'b1;
      eoc_s <= 1'b1;
    end else begin
      eoc_m <= EOC_18;
      eoc_s <= eoc_m;
    end
  end

  // Timer value 1 expires too, so a start lands exactly period_cyc later.
  assign start_ok = PD_18 && enable && (timer <= 16'd1);
  assign to_idle  = (state != IDLE) && (state_n == IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    convst_n = CONVST_18;
    rd_n     = RD_18;
    timer_n  = (timer != '0) ? timer - 16'd1 : '0;
    to_set   = 1'b0;
    cap_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_n  = CONV;
          cnt_n    = '0;
          convst_n = 1'b0;
          timer_n  = period_cyc;
        end
      end
      CONV: begin
        if (cnt == CNT_W'(CONV_LOW_CYC - 1)) begin
          state_n  = WAIT_EOC;
          cnt_n    = '0;
          convst_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_EOC: begin
        if (!eoc_s) begin
          state_n = READ;
          cnt_n   = '0;
          rd_n    = 1'b0;
        end else if (cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          to_set  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      READ: begin
        cap_en = (cnt == CNT_W'(RD_SETUP_CYC - 1));
        if (cnt == CNT_W'(RD_LOW_CYC - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          rd_n    = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      timer       <= '0;
      CONVST_18   <= 1'b1;
      RD_18       <= 1'b1;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      timer     <= timer_n;
      CONVST_18 <= convst_n;
      RD_18     <= rd_n;
      busy      <= (state_n != IDLE);
      if (to_set)
        timeout_err <= 1'b1;
      else if (clear_err)
        timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      cap_vld  <= 1'b0;
      cap_data <= '0;
    end else begin
      cap_vld <= cap_en;
      if (cap_en)
        cap_data <= DB_in;
    end
  end

  assign acc_sum   = acc + ACC_W'(cap_data);
  assign avg_shift = acc_sum >> AVG_LOG2;
  assign avg_out   = avg_shift[DATA_W-1:0];
  assign avg_last  = (avg_cnt == AC_W'(NAVG - 1));

  // A stopped run drops any partial average when it goes idle.
  always_ff @(posedge clk_100M) begin
    if (Reset) begin
      acc          <= '0;
      avg_cnt      <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (cap_vld) begin
        if (avg_last) begin
          sample_out   <= avg_out;
          sample_valid <= 1'b1;
          acc          <= '0;
          avg_cnt      <= '0;
        end else begin
          acc     <= acc_sum;
          avg_cnt <= avg_cnt + AC_W'(1);
        end
      end
      if (to_idle && !enable) begin
        acc     <= '0;
        avg_cnt <= '0;
      end
    end
  end

endmodule
